// File: rtl/rr_index_arbiter_8_if.sv
// Request/grant bundle between the eight requesters and the round-robin index arbiter.
// The slave side is the arbiter; the master side drives requests and done.
interface rr_index_arbiter_8_if;
   logic [7:0] req;
   logic       done;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] grant_onehot;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  grant_valid,
      input  grant_idx,
      input  grant_onehot,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant_valid,
      output grant_idx,
      output grant_onehot,
      output timeout
   );
endinterface

// File: rtl/rr_index_arbiter_8.sv
// Round-robin arbiter over 8 requesters with a registered grant index (decoder input),
// a registered one-hot copy, and a hold limit that forcibly revokes long-held grants.
module rr_index_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_index_arbiter_8_if.slave  bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       onehot_q, onehot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic [2:0] scan_base;
   logic [7:0] req_rot;
   logic [2:0] win_off;
   logic [2:0] winner;
   logic [7:0] win_onehot;
   logic       any_req;
   logic       rel_done, rel_drop, rel_hold, rel_any;

   // On release ptr becomes the old owner, so scanning from idx_q is the same scan one cycle early.
   assign scan_base = (state_q == GRANT) ? idx_q : ptr_q;
   assign any_req   = |bus.req;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign req_rot[gi] = bus.req[scan_base + 3'(gi + 1)];
      end
   endgenerate

   always_comb begin
      win_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_off = 3'(i);
         end
      end
   end

   assign winner = scan_base + 3'd1 + win_off;

   generate
      for (gi = 0; gi < 8; gi++) begin : g_onehot
         assign win_onehot[gi] = (winner == 3'(gi));
      end
   endgenerate

   assign rel_done = bus.done;
   assign rel_drop = ~bus.req[idx_q];
   assign rel_hold = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
   assign rel_any  = rel_done | rel_drop | rel_hold;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      onehot_d  = onehot_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d  = GRANT;
               idx_d    = winner;
               onehot_d = win_onehot;
               cnt_d    = CNT_ONE;
            end
         end
         GRANT: begin
            if (rel_any) begin
               ptr_d     = idx_q;
               timeout_d = rel_hold & ~rel_done & ~rel_drop;
               if (any_req) begin
                  idx_d    = winner;
                  onehot_d = win_onehot;
                  cnt_d    = CNT_ONE;
               end else begin
                  state_d  = IDLE;
                  onehot_d = 8'h00;
                  cnt_d    = '0;
               end
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            onehot_d = 8'h00;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd7;
         idx_q     <= 3'd0;
         onehot_q  <= 8'h00;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         onehot_q  <= onehot_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant_valid  = (state_q == GRANT);
   assign bus.grant_idx    = idx_q;
   assign bus.grant_onehot = onehot_q;
   assign bus.timeout      = timeout_q;

   a_onehot_consistent : assert property (@(posedge clk) disable iff (rst)
      onehot_q == ((state_q == GRANT) ? (8'd1 << idx_q) : 8'd0));

endmodule
